// File: rtl/buttom_conditioner_pkg.sv
// Shared constants and sizing helpers for the button input conditioner.
package buttom_conditioner_pkg;

  // Board-level bus widths and the default debounce timing (1 ms tick at 50 MHz).
  localparam int CPU_WIDTH       = 16;
  localparam int BUTTOMBUS       = CPU_WIDTH;
  localparam int BUTTOM_TICK_DIV = 50000;
  localparam int BUTTOM_SAMPLES  = 4;

  // Width of the per-bit debounce counter: large enough to hold SAMPLES-1 with headroom.
  function automatic int cnt_width(input int samples);
    return $clog2(samples) + 1;
  endfunction

  // Width of the prescaler; a divide-by-one prescaler still needs one bit.
  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/buttom_conditioner_if.sv
// Button bus between the raw pins / CPU side (master) and the conditioner (slave).
interface buttom_conditioner_if import buttom_conditioner_pkg::*; #(
  parameter int WIDTH = CPU_WIDTH
) ();
  logic [WIDTH-1:0] buttom_raw;
  logic [WIDTH-1:0] buttom_stable;
  logic [WIDTH-1:0] rise_pending;
  logic [WIDTH-1:0] fall_pending;
  logic [WIDTH-1:0] clr_mask;
  logic             clr;
  logic             irq;

  modport master (
    output buttom_raw, clr, clr_mask,
    input  buttom_stable, rise_pending, fall_pending, irq
  );

  modport slave (
    input  buttom_raw, clr, clr_mask,
    output buttom_stable, rise_pending, fall_pending, irq
  );
endinterface

// File: rtl/buttom_debounce_bit.sv
// One input bit: two-flop synchroniser, tick-driven debounce counter,
// stable level flop and sticky rise/fall event flags with clear.
module buttom_debounce_bit import buttom_conditioner_pkg::*; #(
  parameter int SAMPLES = BUTTOM_SAMPLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  input  logic i_tick,
  input  logic i_clr_bit,
  output logic o_stable,
  output logic o_rise_pending,
  output logic o_fall_pending
);
  localparam int CW = cnt_width(SAMPLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_stable;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  logic          w_differ;
  logic          w_accept;
  logic          w_set_rise;
  logic          w_set_fall;
  logic          w_stable_nxt;
  logic          w_rise_nxt;
  logic          w_fall_nxt;
  logic [CW-1:0] w_cnt_nxt;

  // Debounce decision and event flag next-state; a set beats a same-edge clear.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_stable_nxt = r_stable;
    w_differ     = (r_sync != r_stable);
    w_accept     = i_tick && w_differ && (r_cnt == CNT_LAST);
    if (!i_tick) begin
      w_cnt_nxt = r_cnt;
    end else if (!w_differ) begin
      w_cnt_nxt = '0;
    end else if (r_cnt == CNT_LAST) begin
      w_cnt_nxt    = '0;
      w_stable_nxt = r_sync;
    end else begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
    w_set_rise = w_accept & r_sync;
    w_set_fall = w_accept & ~r_sync;
    if (w_set_rise) begin
      w_rise_nxt = 1'b1;
    end else if (i_clr_bit) begin
      w_rise_nxt = 1'b0;
    end else begin
      w_rise_nxt = r_rise;
    end
    if (w_set_fall) begin
      w_fall_nxt = 1'b1;
    end else if (i_clr_bit) begin
      w_fall_nxt = 1'b0;
    end else begin
      w_fall_nxt = r_fall;
    end
  end

  // Synchroniser, counter, stable level and pending flags; reset drops any partial count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta   <= i_raw;
      r_sync   <= r_meta;
      r_stable <= w_stable_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign o_stable       = r_stable;
  assign o_rise_pending = r_rise;
  assign o_fall_pending = r_fall;
endmodule

// File: rtl/buttom_conditioner.sv
// Button input conditioner: shared debounce tick prescaler, WIDTH debounced
// bits with sticky edge flags, and a registered summary interrupt.
module buttom_conditioner import buttom_conditioner_pkg::*; #(
  parameter int WIDTH    = BUTTOMBUS,
  parameter int TICK_DIV = BUTTOM_TICK_DIV,
  parameter int SAMPLES  = BUTTOM_SAMPLES
) (
  input  logic clk,
  input  logic rst,
  buttom_conditioner_if.slave bus
);
  localparam int PW = presc_width(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]    r_presc;
  logic [PW-1:0]    w_presc_nxt;
  logic             w_tick;
  logic             r_irq;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  // Prescaler wrap: the tick fires on the last count; divide-by-one ticks every cycle.
  always_comb begin
    w_tick = (r_presc == PRESC_LAST);
    if (w_tick) begin
      w_presc_nxt = '0;
    end else begin
      w_presc_nxt = r_presc + PW'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_presc_nxt;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    buttom_debounce_bit #(
      .SAMPLES(SAMPLES)
    ) u_bit (
      .clk            (clk),
      .rst            (rst),
      .i_raw          (bus.buttom_raw[g]),
      .i_tick         (w_tick),
      .i_clr_bit      (bus.clr & bus.clr_mask[g]),
      .o_stable       (w_stable[g]),
      .o_rise_pending (w_rise[g]),
      .o_fall_pending (w_fall[g])
    );
  end

  // Summary interrupt trails the pending flags by one cycle in both directions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(w_rise | w_fall);
    end
  end

  assign bus.buttom_stable = w_stable;
  assign bus.rise_pending  = w_rise;
  assign bus.fall_pending  = w_fall;
  assign bus.irq           = r_irq;
endmodule

// File: tb/tb_buttom_conditioner.sv
// Self-checking bench for buttom_conditioner (WIDTH=4, TICK_DIV=4, SAMPLES=3)
// with directed scenarios and a randomized run against a behavioural model.
module tb_buttom_conditioner;
  import buttom_conditioner_pkg::*;

  localparam int W  = 4;
  localparam int TD = 4;
  localparam int S  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  buttom_conditioner_if #(.WIDTH(W)) bus ();

  buttom_conditioner #(.WIDTH(W), .TICK_DIV(TD), .SAMPLES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: sync is the raw value two edges back; a bit flips when its
  // last S tick samples all disagree with its current stable level.
  logic [W-1:0] m_stable = '0;
  logic [W-1:0] m_rise   = '0;
  logic [W-1:0] m_fall   = '0;
  logic         m_irq    = 1'b0;
  int           m_edge   = 0;
  logic [W-1:0] m_rawq[$];
  logic [W-1:0] m_tq[$];
  logic [W-1:0] mv_sync, mv_set_r, mv_set_f;
  logic         mv_all;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_stable = '0; m_rise = '0; m_fall = '0; m_irq = 1'b0; m_edge = 0;
      m_rawq.delete(); m_tq.delete();
    end else begin
      m_edge++;
      mv_sync  = (m_edge >= 3) ? m_rawq[m_edge-3] : '0;
      m_irq    = |(m_rise | m_fall);
      mv_set_r = '0;
      mv_set_f = '0;
      if (m_edge % TD == 0) begin
        m_tq.push_back(mv_sync);
        if (m_tq.size() >= S) begin
          for (int b = 0; b < W; b++) begin
            mv_all = 1'b1;
            for (int k = 1; k <= S; k++)
              if (m_tq[m_tq.size()-k][b] == m_stable[b]) mv_all = 1'b0;
            if (mv_all) begin
              if (mv_sync[b]) mv_set_r[b] = 1'b1;
              else            mv_set_f[b] = 1'b1;
            end
          end
        end
        m_stable = m_stable ^ (mv_set_r | mv_set_f);
      end
      if (bus.clr) begin
        m_rise = m_rise & ~bus.clr_mask;
        m_fall = m_fall & ~bus.clr_mask;
      end
      m_rise = m_rise | mv_set_r;
      m_fall = m_fall | mv_set_f;
      m_rawq.push_back(bus.buttom_raw);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.buttom_raw = '0; bus.clr = 1'b0; bus.clr_mask = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int  cyc;
    bit  found;
    @(negedge clk);
    rst = 1'b1; bus.buttom_raw = 4'hF; bus.clr = 1'b0; bus.clr_mask = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.buttom_stable, bus.rise_pending, bus.fall_pending, bus.irq} !== 13'h0) begin
        failures++;
        $display("FAIL reset_hold got=%h/%h/%h/%b want=0/0/0/0", bus.buttom_stable,
                 bus.rise_pending, bus.fall_pending, bus.irq);
      end
    end
    rst = 1'b0; bus.buttom_raw = 4'b0100;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    found = 1'b0; cyc = 0;
    for (int i = 1; i <= 30 && !found; i++) begin
      @(negedge clk);
      if (bus.buttom_stable[2]) begin found = 1'b1; cyc = i; end
    end
    checks++;
    if (!found || cyc < 11 || cyc > 14) begin
      failures++;
      $display("FAIL reset_midcount found=%0b cycles=%0d want 11..14", found, cyc);
    end
    checks++;
    if ({bus.buttom_stable, bus.rise_pending, bus.fall_pending} !== {m_stable, m_rise, m_fall}) begin
      failures++;
      $display("FAIL reset_model got=%h/%h/%h want=%h/%h/%h", bus.buttom_stable, bus.rise_pending,
               bus.fall_pending, m_stable, m_rise, m_fall);
    end
  endtask

  task automatic test_clean_press();
    int cyc;
    bit found;
    logic [12:0] snap;
    do_reset();
    bus.buttom_raw = 4'b0001;
    found = 1'b0; cyc = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      if (bus.buttom_stable[0]) begin found = 1'b1; cyc = i; end
    end
    checks++;
    if (!found || cyc > 14) begin
      failures++;
      $display("FAIL press_latency found=%0b cycles=%0d want <=14", found, cyc);
    end
    checks++;
    if ({bus.rise_pending, bus.fall_pending, bus.irq} !== {4'b0001, 4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL press_flags got rise=%b fall=%b irq=%b want 0001/0000/0", bus.rise_pending,
               bus.fall_pending, bus.irq);
    end
    @(negedge clk);
    checks++;
    if (bus.irq !== 1'b1) begin
      failures++;
      $display("FAIL press_irq got=%b want=1", bus.irq);
    end
    snap = {bus.buttom_stable, bus.rise_pending, bus.fall_pending, bus.irq};
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.buttom_stable, bus.rise_pending, bus.fall_pending, bus.irq} !== snap) begin
        failures++;
        $display("FAIL press_steady cycle=%0d got=%h want=%h", i,
                 {bus.buttom_stable, bus.rise_pending, bus.fall_pending, bus.irq}, snap);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    bus.buttom_raw = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      if (i == 8) bus.buttom_raw = 4'b0000;
      @(negedge clk);
      checks++;
      if ({bus.buttom_stable, bus.rise_pending, bus.fall_pending} !== 12'h0) begin
        failures++;
        $display("FAIL glitch_reject cycle=%0d got=%h/%h/%h want=0/0/0", i, bus.buttom_stable,
                 bus.rise_pending, bus.fall_pending);
      end
    end
    bus.buttom_raw = 4'b0010;
    repeat (16) @(negedge clk);
    checks++;
    if ({bus.buttom_stable, bus.rise_pending} !== {4'b0010, 4'b0010}) begin
      failures++;
      $display("FAIL glitch_accept got stable=%b rise=%b want 0010/0010", bus.buttom_stable,
               bus.rise_pending);
    end
  endtask

  task automatic test_release_clear();
    do_reset();
    bus.buttom_raw = 4'b0001;
    repeat (16) @(negedge clk);
    bus.buttom_raw = 4'b0000;
    repeat (16) @(negedge clk);
    checks++;
    if ({bus.buttom_stable, bus.rise_pending, bus.fall_pending} !== {4'b0000, 4'b0001, 4'b0001}) begin
      failures++;
      $display("FAIL release_fall got=%b/%b/%b want 0000/0001/0001", bus.buttom_stable,
               bus.rise_pending, bus.fall_pending);
    end
    bus.clr = 1'b1; bus.clr_mask = 4'b0001;
    @(negedge clk);
    bus.clr = 1'b0; bus.clr_mask = '0;
    checks++;
    if ({bus.rise_pending, bus.fall_pending, bus.irq} !== {4'b0000, 4'b0000, 1'b1}) begin
      failures++;
      $display("FAIL clear_flags got rise=%b fall=%b irq=%b want 0000/0000/1", bus.rise_pending,
               bus.fall_pending, bus.irq);
    end
    @(negedge clk);
    checks++;
    if (bus.irq !== 1'b0) begin
      failures++;
      $display("FAIL clear_irq got=%b want=0", bus.irq);
    end
  endtask

  task automatic test_collision();
    do_reset();
    bus.buttom_raw = 4'b1000;
    repeat (11) @(negedge clk);
    bus.clr = 1'b1; bus.clr_mask = 4'b1000;
    @(negedge clk);
    bus.clr = 1'b0; bus.clr_mask = '0;
    checks++;
    if ({bus.buttom_stable, bus.rise_pending, bus.fall_pending} !== {4'b1000, 4'b1000, 4'b0000}) begin
      failures++;
      $display("FAIL collision got=%b/%b/%b want 1000/1000/0000", bus.buttom_stable,
               bus.rise_pending, bus.fall_pending);
    end
  endtask

  task automatic test_simultaneous();
    bit found;
    do_reset();
    bus.buttom_raw = 4'b0010;
    repeat (16) @(negedge clk);
    bus.clr = 1'b1; bus.clr_mask = 4'hF;
    @(negedge clk);
    bus.clr = 1'b0; bus.clr_mask = '0; bus.buttom_raw = 4'b0101;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.buttom_stable !== 4'b0010) found = 1'b1;
    end
    checks++;
    if ({bus.buttom_stable, bus.rise_pending, bus.fall_pending} !== {4'b0101, 4'b0101, 4'b0010}) begin
      failures++;
      $display("FAIL simultaneous found=%0b got=%b/%b/%b want 0101/0101/0010", found,
               bus.buttom_stable, bus.rise_pending, bus.fall_pending);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0)
        bus.buttom_raw = bus.buttom_raw ^ (4'b0001 << $urandom_range(0, 3));
      bus.clr      = ($urandom_range(0, 7) == 0);
      bus.clr_mask = 4'($urandom_range(0, 15));
      rst          = ($urandom_range(0, 599) == 0);
      @(negedge clk);
      checks++;
      if ({bus.buttom_stable, bus.rise_pending, bus.fall_pending, bus.irq} !==
          {m_stable, m_rise, m_fall, m_irq}) begin
        failures++;
        errs++;
        if (errs <= 10)
          $display("FAIL random cycle=%0d got=%h/%h/%h/%b want=%h/%h/%h/%b", i, bus.buttom_stable,
                   bus.rise_pending, bus.fall_pending, bus.irq, m_stable, m_rise, m_fall, m_irq);
      end
    end
    rst = 1'b0; bus.clr = 1'b0;
  endtask

  initial begin
    bus.buttom_raw = '0;
    bus.clr        = 1'b0;
    bus.clr_mask   = '0;
    rst            = 1'b1;
    test_reset();
    test_clean_press();
    test_glitch();
    test_release_clear();
    test_collision();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
